// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int          DEFAULT_TIMEOUT  = 16;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

  // Word accesses only: the two low byte-address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Wait-cycle counter for an outstanding memory request. Cleared when a
// request is launched, incremented per unacknowledged BUSY cycle, and
// saturating at TIMEOUT-1 where it raises the terminal-count flag.
module dmem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic Reset,
  input  logic clear,
  input  logic inc,
  output logic term
);

  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Count up while asked to, never past the terminal value.
  always_ff @(posedge clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (inc && !term) begin
      count <= count + W'(1);
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the core's level load/store
// requests into a req/ack bus cycle and stalls the core until the access
// completes, is rejected as misaligned, or times out.
//
// Bus handshake: mem_req is registered and stays high for every BUSY cycle
// with mem_we/mem_addr/mem_wdata stable; mem_ack is sampled only while
// BUSY and completes the cycle, with mem_rdata valid in that same cycle.
// mem_req always drops the cycle after ack (or after timeout) and at least
// one IDLE cycle separates two requests.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  dmem_state_e state, next_state;
  logic        access;
  logic        aligned;
  logic        err_flag;
  logic        timer_clr;
  logic        timer_inc;
  logic        timer_term;

  assign access    = memread | memwrite;
  assign aligned   = is_aligned(address[1:0]);
  assign dbg_state = state;
  assign mem_err   = (state == DONE) && err_flag;

  dmem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock (clock),
    .Reset (Reset),
    .clear (timer_clr),
    .inc   (timer_inc),
    .term  (timer_term)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, stall and timer control.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (aligned) begin
            timer_clr  = 1'b1;
            next_state = BUSY;
          end else begin
            next_state = DONE;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || timer_term) begin
          next_state = DONE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      DONE: begin
        // The core advances this cycle; its next instruction is seen in IDLE.
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request strobe: high exactly while the FSM sits in BUSY.
  always_ff @(posedge clock) begin
    if (Reset) begin
      mem_req <= 1'b0;
    end else begin
      mem_req <= (next_state == BUSY);
    end
  end

  // Bus fields, error flag and load-data register.
  always_ff @(posedge clock) begin
    if (Reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_flag  <= 1'b0;
      readdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            err_flag <= !aligned;
            if (aligned) begin
              // A store wins when both controls are high.
              mem_we    <= memwrite;
              mem_addr  <= address[31:2];
              mem_wdata <= writedata;
            end else if (!memwrite) begin
              readdata <= ERR_DATA;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            err_flag <= 1'b0;
            if (!mem_we) begin
              readdata <= mem_rdata;
            end
          end else if (timer_term) begin
            err_flag <= 1'b1;
            if (!mem_we) begin
              readdata <= ERR_DATA;
            end
          end
        end
        DONE: begin
          err_flag <= 1'b0;
        end
        default: begin
          err_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one task per scenario, inline checks.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        Reset;
  logic        memread, memwrite;
  logic [31:0] address, writedata;
  logic [31:0] readdata;
  logic        stall, mem_err, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by the access driver.
  int          r_stall, r_req, r_err;
  logic [31:0] r_rdata, r_wdata;
  logic [29:0] r_addr;
  logic        r_we, r_ok;

  dmem_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: present one request and play the memory side. ack_wait is the
  // BUSY-cycle index (0-based) at which ack is returned; -1 never acks.
  // Samples are taken 2 time units after each rising edge.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_wait,
                            input logic [31:0] rdata);
    r_stall = 0; r_req = 0; r_err = 0; r_ok = 1'b0;
    r_addr = '0; r_we = 1'b0; r_wdata = '0; r_rdata = '0;
    memread = rd; memwrite = wr; address = addr; writedata = wd;
    for (int c = 0; c < 100 && !r_ok; c++) begin
      #1;
      if (mem_req) begin
        mem_ack   = (r_req == ack_wait);
        mem_rdata = rdata;
        r_addr    = mem_addr;
        r_we      = mem_we;
        r_wdata   = mem_wdata;
        r_req++;
      end else begin
        mem_ack = 1'b0;
      end
      if (mem_err) r_err++;
      if (stall) begin
        r_stall++;
      end else begin
        r_ok     = 1'b1;
        r_rdata  = readdata;
        memread  = 1'b0;
        memwrite = 1'b0;
      end
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; memread = 0; memwrite = 0; address = 0; writedata = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (3) tick();
    Reset = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", mem_err); end
    n_checks++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we got %b exp 00", {mem_req, mem_we}); end
    n_checks++; if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    tick();
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D);
    n_checks++; if (r_ok !== 1'b1) begin n_fail++; $display("FAIL load_done got %b exp 1", r_ok); end
    n_checks++; if (r_stall !== 2) begin n_fail++; $display("FAIL load_stall got %0d exp 2", r_stall); end
    n_checks++; if (r_req !== 1) begin n_fail++; $display("FAIL load_req got %0d exp 1", r_req); end
    n_checks++; if (r_addr !== 30'h4 || r_we !== 1'b0) begin n_fail++; $display("FAIL load_addr got %h/%b exp 4/0", r_addr, r_we); end
    n_checks++; if (r_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_rdata got %h exp cafef00d", r_rdata); end
    n_checks++; if (r_err !== 0) begin n_fail++; $display("FAIL load_err got %0d exp 0", r_err); end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_FFFF);
    n_checks++; if (r_stall !== 5) begin n_fail++; $display("FAIL store_stall got %0d exp 5", r_stall); end
    n_checks++; if (r_req !== 4) begin n_fail++; $display("FAIL store_req got %0d exp 4", r_req); end
    n_checks++; if (r_we !== 1'b1 || r_addr !== 30'h8) begin n_fail++; $display("FAIL store_we_addr got %b/%h exp 1/8", r_we, r_addr); end
    n_checks++; if (r_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL store_wdata got %h exp 12345678", r_wdata); end
    n_checks++; if (r_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_readdata got %h exp cafef00d", r_rdata); end
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 32'h0000_0003, 32'h0, 0, 32'h0);
    n_checks++; if (r_stall !== 1) begin n_fail++; $display("FAIL mis_stall got %0d exp 1", r_stall); end
    n_checks++; if (r_req !== 0) begin n_fail++; $display("FAIL mis_req got %0d exp 0", r_req); end
    n_checks++; if (r_err !== 1) begin n_fail++; $display("FAIL mis_err got %0d exp 1", r_err); end
    n_checks++; if (r_rdata !== ERR) begin n_fail++; $display("FAIL mis_rdata got %h exp %h", r_rdata, ERR); end
  endtask

  task automatic test_timeout();
    // Put a non-error value in readdata first so the error write is visible.
    run_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h5555_AAAA);
    run_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, -1, 32'h0);
    n_checks++; if (r_req !== TO) begin n_fail++; $display("FAIL to_req got %0d exp %0d", r_req, TO); end
    n_checks++; if (r_stall !== TO + 1) begin n_fail++; $display("FAIL to_stall got %0d exp %0d", r_stall, TO + 1); end
    n_checks++; if (r_err !== 1) begin n_fail++; $display("FAIL to_err got %0d exp 1", r_err); end
    n_checks++; if (r_rdata !== ERR) begin n_fail++; $display("FAIL to_rdata got %h exp %h", r_rdata, ERR); end
    // Late ack while IDLE must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    #1;
    n_checks++; if ({stall, mem_req, mem_err} !== 3'b000) begin n_fail++; $display("FAIL late_ack got %b exp 000", {stall, mem_req, mem_err}); end
    n_checks++; if (dbg_state !== IDLE || readdata !== ERR) begin n_fail++; $display("FAIL late_ack_state got %0d/%h exp 0/%h", dbg_state, readdata, ERR); end
    tick();
  endtask

  task automatic test_reset_busy();
    memread = 1'b1; address = 32'h0000_0030;
    tick();
    tick();
    #1;
    n_checks++; if (mem_req !== 1'b1 || dbg_state !== BUSY) begin n_fail++; $display("FAIL rb_busy got %b/%0d exp 1/1", mem_req, dbg_state); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; memread = 1'b0;
    #1;
    n_checks++; if ({mem_req, stall, mem_err} !== 3'b000) begin n_fail++; $display("FAIL rb_after got %b exp 000", {mem_req, stall, mem_err}); end
    n_checks++; if (dbg_state !== IDLE || readdata !== 32'h0) begin n_fail++; $display("FAIL rb_state got %0d/%h exp 0/0", dbg_state, readdata); end
    tick();
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hA5A5_5A5A);
    n_checks++; if (r_stall !== 3 || r_req !== 2 || r_err !== 0) begin n_fail++; $display("FAIL rb_next got %0d/%0d/%0d exp 3/2/0", r_stall, r_req, r_err); end
    n_checks++; if (r_rdata !== 32'hA5A5_5A5A || r_addr !== 30'h11) begin n_fail++; $display("FAIL rb_next_data got %h/%h exp a5a55a5a/11", r_rdata, r_addr); end
  endtask

  task automatic test_both_high();
    run_access(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0BAD_0BAD);
    n_checks++; if (r_we !== 1'b1 || r_addr !== 30'h10) begin n_fail++; $display("FAIL both_we got %b/%h exp 1/10", r_we, r_addr); end
    n_checks++; if (r_wdata !== 32'hDEAD_BEEF || r_err !== 0) begin n_fail++; $display("FAIL both_wdata got %h/%0d exp deadbeef/0", r_wdata, r_err); end
    n_checks++; if (r_rdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL both_readdata got %h exp a5a55a5a", r_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  req_tr, stall_tr;
    logic [29:0] addr2;
    req_tr = '0; stall_tr = '0; addr2 = '0;
    memread = 1'b1; address = 32'h0000_0050; mem_rdata = 32'h1111_2222;
    for (int c = 0; c < 6; c++) begin
      #1;
      req_tr[5-c]   = mem_req;
      stall_tr[5-c] = stall;
      mem_ack = mem_req;
      if (c == 4) addr2 = mem_addr;
      if (c == 2) address = 32'h0000_0054;
      tick();
    end
    memread = 1'b0; mem_ack = 1'b0;
    n_checks++; if (req_tr !== 6'b010010) begin n_fail++; $display("FAIL b2b_req got %b exp 010010", req_tr); end
    n_checks++; if (stall_tr !== 6'b110110) begin n_fail++; $display("FAIL b2b_stall got %b exp 110110", stall_tr); end
    n_checks++; if (addr2 !== 30'h15) begin n_fail++; $display("FAIL b2b_addr got %h exp 15", addr2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_both_high();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
